// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sr_ctrl_pkg
// Description : Shared definitions for the SR drive controller: FSM state
//               encoding, counter width and parameter default values.
// Revision    : 1.0 - initial release
// ============================================================================
package sr_ctrl_pkg;

    // Controller states, explicitly encoded on two bits.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_CHECK = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    // Default parameter values.
    localparam int unsigned c_DEBOUNCE_DEF = 4;
    localparam int unsigned c_PULSE_W_DEF  = 2;
    localparam int unsigned c_TIMEOUT_DEF  = 8;

    // Shared pulse/timeout counter width (covers TIMEOUT up to 255).
    localparam int unsigned c_CNT_W = 8;

endpackage
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sr_debounce
// Description : Two-flop synchronizer followed by a debouncer. The debounced
//               level follows the synchronized input only after the two have
//               differed on DEBOUNCE consecutive edges. A one-cycle rise
//               pulse marks each 0->1 change of the debounced level.
// Revision    : 1.0 - initial release
// Ports       : clk_i  - clock
//               rst_i  - synchronous active-high reset
//               req_i  - asynchronous request level
//               rise_o - one-cycle pulse on debounced 0->1 transition
// ============================================================================
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = c_DEBOUNCE_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic rise_o
);

    localparam logic [3:0] c_TERM = 4'(DEBOUNCE - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       level_q;
    logic       rise_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            // Any edge where the input agrees with the debounced level
            // restarts the stability count, so the count never wraps.
            if (sync2_q == level_q) begin
                cnt_q <= 4'd0;
            end else if (cnt_q == c_TERM) begin
                level_q <= sync2_q;
                rise_q  <= sync2_q;
                cnt_q   <= 4'd0;
            end else begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/sr_drive_controller.sv
`default_nettype none
// ============================================================================
// Module      : sr_drive_controller
// Description : Debounces set/clear request levels and drives a downstream SR
//               flip-flop with a fixed-width S or R pulse, then waits for the
//               flip-flop's Q to confirm the new value. Missing confirmation
//               within TIMEOUT cycles latches a fault until acknowledged.
// Revision    : 1.0 - initial release
// Ports       : Clk      - clock
//               Rst      - synchronous active-high reset
//               SetReq   - asynchronous set request level
//               ClrReq   - asynchronous clear request level
//               ErrClr   - fault acknowledge
//               Q_fb     - Q of downstream flip-flop (same clock domain)
//               S, R     - set / reset drive pulses
//               Busy     - controller not idle
//               Done     - one-cycle confirmed-completion pulse
//               Conflict - one-cycle pulse on simultaneous set and clear
//               Err      - high while faulted
// ============================================================================
module sr_drive_controller
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = c_DEBOUNCE_DEF,
    parameter int unsigned PULSE_W  = c_PULSE_W_DEF,
    parameter int unsigned TIMEOUT  = c_TIMEOUT_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic SetReq,
    input  logic ClrReq,
    input  logic ErrClr,
    input  logic Q_fb,
    output logic S,
    output logic R,
    output logic Busy,
    output logic Done,
    output logic Conflict,
    output logic Err
);

    localparam logic [c_CNT_W-1:0] c_PULSE_TERM   = c_CNT_W'(PULSE_W - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_TERM = c_CNT_W'(TIMEOUT - 1);

    logic               set_ev;
    logic               clr_ev;
    state_t             state_q,    state_d;
    logic [c_CNT_W-1:0] cnt_q,      cnt_d;
    logic               target_q,   target_d;
    logic               s_q,        s_d;
    logic               r_q,        r_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               conflict_q, conflict_d;
    logic               err_q,      err_d;

    sr_debounce #(.DEBOUNCE(DEBOUNCE)) u_set_db (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .req_i  (SetReq),
        .rise_o (set_ev)
    );

    sr_debounce #(.DEBOUNCE(DEBOUNCE)) u_clr_db (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .req_i  (ClrReq),
        .rise_o (clr_ev)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        done_d     = 1'b0;
        conflict_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (set_ev && clr_ev) begin
                    conflict_d = 1'b1;
                end else if (set_ev) begin
                    state_d  = ST_PULSE;
                    target_d = 1'b1;
                end else if (clr_ev) begin
                    state_d  = ST_PULSE;
                    target_d = 1'b0;
                end
            end
            ST_PULSE: begin
                if (cnt_q == c_PULSE_TERM) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CHECK: begin
                if (Q_fb == target_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q == c_TIMEOUT_TERM) begin
                    state_d = ST_FAULT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FAULT: begin
                if (ErrClr) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // alongside it; S and R are mutually exclusive by target.
        s_d    = (state_d == ST_PULSE) &&  target_d;
        r_d    = (state_d == ST_PULSE) && !target_d;
        busy_d = (state_d != ST_IDLE);
        err_d  = (state_d == ST_FAULT);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            target_q   <= 1'b0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            s_q        <= s_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
            err_q      <= err_d;
        end
    end

    assign S        = s_q;
    assign R        = r_q;
    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Conflict = conflict_q;
    assign Err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_drive_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_drive_controller
// Description : Self-checking bench for sr_drive_controller. Directed steps
//               push expected output vectors {S,R,Busy,Done,Conflict,Err}
//               tagged with the cycle they must appear in; a monitor pops and
//               compares them, and checks S/R exclusivity and that every Done
//               follows a matching pulse. A random phase closes the run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_drive_controller;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic SetReq = 1'b0;
    logic ClrReq = 1'b0;
    logic ErrClr = 1'b0;
    logic Q_fb;
    logic S, R, Busy, Done, Conflict, Err;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   q_mode = 0;      // 0: SR-flop model, 1: stuck at 1, 2: model with noise
    logic q_r = 1'b0;

    typedef struct {
        int         cyc;
        logic [5:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    sr_drive_controller dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .SetReq   (SetReq),
        .ClrReq   (ClrReq),
        .ErrClr   (ErrClr),
        .Q_fb     (Q_fb),
        .S        (S),
        .R        (R),
        .Busy     (Busy),
        .Done     (Done),
        .Conflict (Conflict),
        .Err      (Err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Downstream SR flip-flop model.
    always @(posedge Clk) begin
        if (Rst)              q_r <= 1'b0;
        else if (q_mode == 1) q_r <= 1'b1;
        else if (q_mode == 2 && $urandom_range(3) == 0) q_r <= ~q_r;
        else if (S)           q_r <= 1'b1;
        else if (R)           q_r <= 1'b0;
    end
    assign Q_fb = q_r;

    // Monitor: sampled 1 time unit after each rising edge.
    logic pend = 1'b0;
    logic pend_kind = 1'b0;
    always @(posedge Clk) begin
        logic       q_edge;
        logic       rst_edge;
        logic [5:0] obs;
        exp_t       e;
        q_edge   = Q_fb;
        rst_edge = Rst;
        #1;
        obs = {S, R, Busy, Done, Conflict, Err};

        vectors++;
        assert (!(S === 1'b1 && R === 1'b1)) else begin
            miscompares++;
            $error("FAIL sr_exclusive cyc=%0d observed S=%b R=%b expected not both 1", cyc, S, R);
        end

        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.cyc < cyc) begin
                miscompares++;
                $error("FAIL %s stale entry cyc=%0d observed=none expected=%b", e.tag, e.cyc, e.val);
            end else begin
                assert (obs === e.val) else begin
                    miscompares++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b", e.tag, cyc, obs, e.val);
                end
            end
        end

        if (rst_edge) begin
            pend = 1'b0;
        end else begin
            if (S === 1'b1 || R === 1'b1) begin
                pend      = 1'b1;
                pend_kind = (S === 1'b1);
            end
            if (Done === 1'b1) begin
                vectors++;
                assert (pend === 1'b1 && q_edge === pend_kind) else begin
                    miscompares++;
                    $error("FAIL done_match cyc=%0d observed pend=%b q=%b expected pend=1 q=%b",
                           cyc, pend, q_edge, pend_kind);
                end
                pend = 1'b0;
            end
            if (Err === 1'b1) pend = 1'b0;
        end
    end

    // Push expected vector v for "after relative edge k", k0..k1.
    task automatic expect_rng(input int base, input int k0, input int k1,
                              input logic [5:0] v, input string tag);
        for (int k = k0; k <= k1; k++) begin
            exp_t e;
            e.cyc = base + k + 1;
            e.val = v;
            e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic idle_wait(input string tag, input int n);
        expect_rng(cyc, 0, n - 1, 6'b000000, tag);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;

        // Reset state
        @(negedge Clk);
        @(negedge Clk);
        expect_rng(cyc, 0, 0, 6'b000000, "reset");
        @(negedge Clk);
        Rst = 1'b0;
        idle_wait("post_reset", 4);

        // Set path: S after edges 6,7; CHECK at 8; Done at 9
        base = cyc;
        SetReq = 1'b1;
        expect_rng(base, 0, 5,  6'b000000, "set_wait");
        expect_rng(base, 6, 7,  6'b101000, "set_pulse");
        expect_rng(base, 8, 8,  6'b001000, "set_check");
        expect_rng(base, 9, 9,  6'b000100, "set_done");
        expect_rng(base, 10, 12, 6'b000000, "set_idle");
        repeat (13) @(negedge Clk);
        SetReq = 1'b0;
        idle_wait("set_release", 10);

        // Bounce: toggling input never qualifies
        base = cyc;
        expect_rng(base, 0, 19, 6'b000000, "bounce");
        for (int i = 0; i < 10; i++) begin
            SetReq = (i % 2 == 0);
            @(negedge Clk);
        end
        SetReq = 1'b0;
        repeat (10) @(negedge Clk);

        // Simultaneous set and clear
        base = cyc;
        SetReq = 1'b1;
        ClrReq = 1'b1;
        expect_rng(base, 0, 5,  6'b000000, "conf_wait");
        expect_rng(base, 6, 6,  6'b000010, "conflict");
        expect_rng(base, 7, 12, 6'b000000, "conf_idle");
        repeat (13) @(negedge Clk);
        SetReq = 1'b0;
        ClrReq = 1'b0;
        idle_wait("conf_release", 10);

        // Timeout with Q_fb stuck at 1, requests ignored in FAULT, ErrClr
        base = cyc;
        q_mode = 1;
        ClrReq = 1'b1;
        expect_rng(base, 0, 5,   6'b000000, "to_wait");
        expect_rng(base, 6, 7,   6'b011000, "to_rpulse");
        expect_rng(base, 8, 15,  6'b001000, "to_check");
        expect_rng(base, 16, 29, 6'b001001, "to_fault");
        expect_rng(base, 30, 40, 6'b000000, "to_cleared");
        for (int n = 1; n <= 41; n++) begin
            @(negedge Clk);
            if (n == 10) ClrReq = 1'b0;
            if (n == 17) SetReq = 1'b1;
            if (n == 30) ErrClr = 1'b1;
            if (n == 31) ErrClr = 1'b0;
        end
        SetReq = 1'b0;
        q_mode = 0;
        idle_wait("to_release", 10);

        // Reset during first S cycle, request still held
        base = cyc;
        SetReq = 1'b1;
        expect_rng(base, 0, 5,   6'b000000, "rst_wait");
        expect_rng(base, 6, 6,   6'b101000, "rst_pulse1");
        expect_rng(base, 7, 13,  6'b000000, "rst_cleared");
        expect_rng(base, 14, 15, 6'b101000, "rst_pulse2");
        expect_rng(base, 16, 16, 6'b001000, "rst_check");
        expect_rng(base, 17, 17, 6'b000100, "rst_done");
        expect_rng(base, 18, 25, 6'b000000, "rst_idle");
        for (int n = 1; n <= 26; n++) begin
            @(negedge Clk);
            if (n == 7) Rst = 1'b1;
            if (n == 8) Rst = 1'b0;
        end
        SetReq = 1'b0;
        idle_wait("rst_release", 10);

        // Random phase: monitor checks exclusivity and Done provenance
        q_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(7) == 0)    SetReq = ~SetReq;
            if ($urandom_range(7) == 0)    ClrReq = ~ClrReq;
            ErrClr = ($urandom_range(15) == 0);
            Rst    = ($urandom_range(1499) == 0);
            @(negedge Clk);
        end
        Rst = 1'b0;
        ErrClr = 1'b0;
        SetReq = 1'b0;
        ClrReq = 1'b0;
        repeat (5) @(negedge Clk);

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain observed=%0d pending expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
